// File: rtl/chunked_add_pkg.sv
// Shared types and helpers for the chunked add/subtract sequencer.
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // A single-chunk configuration still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/FastAdder2.sv
// Two-level carry-lookahead adder: HEIGHT groups of WIDTH bits, group-level
// generate/propagate exported so a caller can chain chunks through a carry FF.
module FastAdder2 #(
  parameter int WIDTH  = 2,
  parameter int HEIGHT = 2
) (
  input  logic [WIDTH*HEIGHT-1:0] a_in,
  input  logic [WIDTH*HEIGHT-1:0] b_in,
  input  logic                    c_in,
  output logic [WIDTH*HEIGHT-1:0] sum_out,
  output logic                    gg_out,
  output logic                    pg_out
);

  logic [WIDTH*HEIGHT-1:0] bit_g;
  logic [WIDTH*HEIGHT-1:0] bit_p;

  assign bit_g = a_in & b_in;
  assign bit_p = a_in ^ b_in;

  always_comb begin : adder_tree
    logic group_cy;
    logic ripple_cy;
    logic grp_g;
    logic grp_p;
    sum_out  = '0;
    gg_out   = 1'b0;
    pg_out   = 1'b1;
    group_cy = c_in;
    for (int h = 0; h < HEIGHT; h++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int w = 0; w < WIDTH; w++) begin
        grp_g = bit_g[h*WIDTH+w] | (bit_p[h*WIDTH+w] & grp_g);
        grp_p = grp_p & bit_p[h*WIDTH+w];
      end
      ripple_cy = group_cy;
      for (int w = 0; w < WIDTH; w++) begin
        sum_out[h*WIDTH+w] = bit_p[h*WIDTH+w] ^ ripple_cy;
        ripple_cy = bit_g[h*WIDTH+w] | (bit_p[h*WIDTH+w] & ripple_cy);
      end
      // Group carry comes from lookahead terms, not from the ripple above.
      group_cy = grp_g | (grp_p & group_cy);
      gg_out   = grp_g | (grp_p & gg_out);
      pg_out   = pg_out & grp_p;
    end
  end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle add/subtract: one FastAdder2 reused across CHUNKS slices of the
// operands, carry held in a flip-flop between slices.
module chunked_add_sequencer
  import chunked_add_pkg::*;
#(
  parameter int ADDER_WIDTH  = 2,
  parameter int ADDER_HEIGHT = 2,
  parameter int CHUNK_BITS   = 4,
  parameter int CHUNKS       = 4,
  parameter int TOTAL_BITS   = CHUNK_BITS * CHUNKS
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  sub_in,
  input  logic [TOTAL_BITS-1:0] a_in,
  input  logic [TOTAL_BITS-1:0] b_in,
  input  logic                  c_in,
  output logic                  ready_out,
  output logic                  done_out,
  output logic [TOTAL_BITS-1:0] sum_out,
  output logic                  c_out,
  output logic                  v_out,
  output logic                  z_out
);

  localparam int IDX_W = idx_width(CHUNKS);
  localparam int MSB   = TOTAL_BITS - 1;

  if (CHUNK_BITS != ADDER_WIDTH * ADDER_HEIGHT) begin : g_cfg_check
    $error("CHUNK_BITS must equal ADDER_WIDTH*ADDER_HEIGHT");
  end

  add_state_t            state_q, state_d;
  logic [TOTAL_BITS-1:0] a_q, b_q, work_q, work_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  carry_q, carry_d;
  logic [CHUNK_BITS-1:0] a_chunk, b_chunk, chunk_sum;
  logic                  chunk_gg, chunk_pg;
  logic                  last_chunk, accept, msb_carry_in;

  assign a_chunk = a_q[idx_q*CHUNK_BITS +: CHUNK_BITS];
  assign b_chunk = b_q[idx_q*CHUNK_BITS +: CHUNK_BITS];

  FastAdder2 #(
    .WIDTH  (ADDER_WIDTH),
    .HEIGHT (ADDER_HEIGHT)
  ) u_adder (
    .a_in    (a_chunk),
    .b_in    (b_chunk),
    .c_in    (carry_q),
    .sum_out (chunk_sum),
    .gg_out  (chunk_gg),
    .pg_out  (chunk_pg)
  );

  assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));
  assign accept     = start_in & ready_out;

  // Registers: reset covers control and visible results only.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_out <= '0;
      c_out   <= 1'b0;
      v_out   <= 1'b0;
      z_out   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a_in;
        b_q     <= sub_in ? ~b_in : b_in;
        carry_q <= c_in ^ sub_in;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        work_q  <= work_d;
        carry_q <= carry_d;
        idx_q   <= last_chunk ? '0 : idx_q + 1'b1;
        // Results are taken straight from the final slice so DONE shows them.
        if (last_chunk) begin
          sum_out <= work_d;
          c_out   <= carry_d;
          v_out   <= carry_d ^ msb_carry_in;
          z_out   <= (work_d == '0);
        end
      end
    end
  end

  // Next state and datapath next values.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = start_in ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    carry_d = chunk_gg | (chunk_pg & carry_q);
    work_d  = work_q;
    work_d[idx_q*CHUNK_BITS +: CHUNK_BITS] = chunk_sum;
    msb_carry_in = a_q[MSB] ^ b_q[MSB] ^ work_d[MSB];
  end

  // Handshake outputs.
  always_comb begin
    ready_out = (state_q != RUN);
    done_out  = (state_q == DONE);
  end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Scoreboard bench for chunked_add_sequencer: directed corner cases plus random ops.
module tb_chunked_add_sequencer;

  localparam int CHUNKS     = 4;
  localparam int CHUNK_BITS = 4;
  localparam int W          = CHUNKS * CHUNK_BITS;
  localparam int LAT        = CHUNKS + 1;

  logic         clk_in = 1'b0;
  logic         reset_in, start_in, sub_in, c_in;
  logic [W-1:0] a_in, b_in;
  logic         ready_out, done_out, c_out, v_out, z_out;
  logic [W-1:0] sum_out;

  chunked_add_sequencer #(
    .ADDER_WIDTH  (2),
    .ADDER_HEIGHT (2),
    .CHUNK_BITS   (CHUNK_BITS),
    .CHUNKS       (CHUNKS)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .start_in  (start_in),
    .sub_in    (sub_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .ready_out (ready_out),
    .done_out  (done_out),
    .sum_out   (sum_out),
    .c_out     (c_out),
    .v_out     (v_out),
    .z_out     (z_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from the signed value range.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin, input int due);
    exp_t         e;
    logic [W-1:0] bb;
    longint       full, ss;
    logic         cy;
    cy   = cin ^ sub;
    bb   = sub ? ~b : b;
    full = longint'(a) + longint'(bb) + longint'(cy);
    ss   = longint'($signed(a)) + longint'($signed(bb)) + longint'(cy);
    e.sum = full[W-1:0];
    e.c   = full[W];
    e.v   = (ss > 32767) || (ss < -32768);
    e.z   = (e.sum == '0);
    e.due = due;
    return e;
  endfunction

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
    int guard = 0;
    while (ready_out !== 1'b1 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 50) begin
      check("ready_wait_timeout", 0, 1);
      return;
    end
    start_in = 1'b1;
    a_in     = a;
    b_in     = b;
    sub_in   = sub;
    c_in     = cin;
    sb_q.push_back(model(a, b, sub, cin, cyc + LAT));
    @(negedge clk_in);
    start_in = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    sub_in   = 1'($urandom);
    c_in     = 1'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, ready_out, 1);
    check({tag, "_done"},  done_out,  0);
    check({tag, "_sum"},   sum_out,   0);
    check({tag, "_c"},     c_out,     0);
    check({tag, "_v"},     v_out,     0);
    check({tag, "_z"},     z_out,     0);
  endtask

  task automatic mid_run_pulse();
    start_in = 1'b1;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    check("ready_low_in_run", ready_out, 0);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  // Monitor: pops an expectation for every done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sum",     sum_out, e.sum);
          check("c_out",   c_out,   e.c);
          check("v_out",   v_out,   e.v);
          check("z_out",   z_out,   e.z);
          check("latency", cyc,     e.due);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int guard;
    reset_in = 1'b1;
    start_in = 1'b0;
    sub_in   = 1'b0;
    c_in     = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk_in);
    check_reset_state("reset");
    reset_in = 1'b0;
    @(negedge clk_in);

    do_start(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("ready_low_in_run", ready_out, 0);
    do_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_start(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_start(16'h0005, 16'h0007, 1'b1, 1'b0);
    do_start(16'h0007, 16'h0005, 1'b1, 1'b0);

    // Back-to-back with an ignored start pulse in the middle of RUN.
    do_start(16'h1234, 16'h1111, 1'b0, 1'b0);
    mid_run_pulse();
    guard = 0;
    while (ready_out !== 1'b1 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    check("b2b_start_in_done", done_out, 1);
    do_start(16'h8000, 16'h8000, 1'b0, 1'b1);

    // Reset during the second RUN cycle aborts the operation.
    do_start(16'hABCD, 16'h1357, 1'b0, 1'b0);
    @(negedge clk_in);
    reset_in = 1'b1;
    sb_q.delete();
    @(negedge clk_in);
    reset_in = 1'b0;
    check_reset_state("abort");
    repeat (LAT + 2) @(negedge clk_in);

    // Reset wins over a simultaneous start.
    reset_in = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    start_in = 1'b0;
    check("rst_prio_ready", ready_out, 1);

    do_start(16'h4321, 16'h0FF0, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      do_start(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) mid_run_pulse();
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
